// File: rtl/wave_seq_pkg.sv
// Shared definitions for the wave_gen sequencer: wave_gen register indices and mode
// codes, sequencer register map, table entry layout, table field selects and FSM states.
package wave_seq_pkg;

  // wave_gen register indices; the bus address is {28'b0, idx, 2'b00}
  typedef enum logic [1:0] {
    WgMode   = 2'd0,
    WgParam1 = 2'd1,
    WgParam2 = 2'd2
  } wg_reg_e;

  // wave_gen mode codes
  typedef enum logic [2:0] {
    ModeOff    = 3'd0,
    ModeToggle = 3'd1,
    ModePwm    = 3'd2,
    ModeSquare = 3'd3,
    ModeRect   = 3'd4,
    ModeTri    = 3'd5,
    ModeSaw    = 3'd6,
    ModeSine   = 3'd7
  } wg_mode_e;

  // Sequencer register map, selected by addr[5:2]
  localparam logic [3:0] WsCtrl   = 4'd0;
  localparam logic [3:0] WsStatus = 4'd1;
  localparam logic [3:0] WsCount  = 4'd2;
  localparam logic [3:0] WsTidx   = 4'd3;
  localparam logic [3:0] WsTmode  = 4'd4;
  localparam logic [3:0] WsTp1    = 4'd5;
  localparam logic [3:0] WsTp2    = 4'd6;
  localparam logic [3:0] WsTdur   = 4'd7;

  // Table field select; matches addr[3:2] of the TMODE..TDUR registers
  typedef enum logic [1:0] {
    FldMode = 2'd0,
    FldP1   = 2'd1,
    FldP2   = 2'd2,
    FldDur  = 2'd3
  } tbl_field_e;

  // One table step, 59 bits
  typedef struct packed {
    logic [2:0]  mode;
    logic [11:0] p1;
    logic [11:0] p2;
    logic [31:0] dur;
  } wave_entry_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StWrMode = 3'd2,
    StWrP1   = 3'd3,
    StWrP2   = 3'd4,
    StHold   = 3'd5,
    StWrOff  = 3'd6
  } seq_state_e;

  function automatic logic [31:0] wg_reg_addr(wg_reg_e r);
    return {28'b0, r, 2'b00};
  endfunction

endpackage

// File: rtl/wave_seq_if.sv
// Bus bundle around the sequencer: CPU-side iomem strobe bus (wstrb/addr/wdata/rdata),
// the wave_gen write port driven by the sequencer (wg_*) and the done interrupt.
//  slave  : the sequencer (takes CPU writes, drives readback, wave_gen port and irq)
//  master : the CPU / decoder side, which also observes the wave_gen port
interface wave_seq_if;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  wg_wstrb;
  logic [31:0] wg_addr;
  logic [31:0] wg_wdata;
  logic        irq;

  modport master (
    output wstrb, addr, wdata,
    input  rdata, wg_wstrb, wg_addr, wg_wdata, irq
  );

  modport slave (
    input  wstrb, addr, wdata,
    output rdata, wg_wstrb, wg_addr, wg_wdata, irq
  );
endinterface

// File: rtl/wave_seq_table.sv
// Step table for the sequencer: Depth x 59-bit flop array.
//  clk, reset      : clock, synchronous active-high reset (zeroes every entry)
//  we_i            : write enable; widx_i selects the entry, wfield_i the field
//  wdata_i         : write data, truncated to the field width
//  cpu_idx_i/_o    : readback port for the CPU (entry at TIDX)
//  seq_idx_i/_o    : read port used by the sequencer LOAD state
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned IdxW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_i,
  input  logic [IdxW-1:0] widx_i,
  input  tbl_field_e      wfield_i,
  input  logic [31:0]     wdata_i,
  input  logic [IdxW-1:0] cpu_idx_i,
  output wave_entry_t     cpu_entry_o,
  input  logic [IdxW-1:0] seq_idx_i,
  output wave_entry_t     seq_entry_o
);

  wave_entry_t mem_q [Depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      unique case (wfield_i)
        FldMode: mem_q[widx_i].mode <= wdata_i[2:0];
        FldP1:   mem_q[widx_i].p1   <= wdata_i[11:0];
        FldP2:   mem_q[widx_i].p2   <= wdata_i[11:0];
        FldDur:  mem_q[widx_i].dur  <= wdata_i;
        default: ;
      endcase
    end
  end

  assign cpu_entry_o = mem_q[cpu_idx_i];
  assign seq_entry_o = mem_q[seq_idx_i];

endmodule

// File: rtl/wave_seq.sv
// Autonomous sequencer for wave_gen. The CPU fills a step table (mode/p1/p2/dur) over the
// strobe bus; on start the table is played as wave_gen writes MODE, PARAM1, PARAM2, then the
// step is held for dur cycles. At the end the sequence loops or parks wave_gen in OFF.
//  clk   : system clock
//  reset : synchronous active-high reset
//  bus   : slave side of wave_seq_if (CPU writes/readback, wave_gen write port, irq)
module wave_seq
  import wave_seq_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned IdxW  = 3
) (
  input logic       clk,
  input logic       reset,
  wave_seq_if.slave bus
);

  localparam int unsigned CntW = IdxW + 1;

  seq_state_e      state_q, state_d;
  logic            loop_q, loop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] tidx_q, tidx_d;
  logic [IdxW-1:0] cur_idx_q, cur_idx_d;
  logic            done_q, done_d;
  wave_entry_t     work_q, work_d;
  logic [31:0]     hold_cnt_q, hold_cnt_d;

  wave_entry_t cpu_entry, seq_entry;

  logic       wr, ctrl_wr, tbl_we;
  logic [3:0] sel;
  logic       busy, start_go, stop_go, hold_zero, last_step;

  logic [31:0] rdata, wg_addr, wg_wdata;
  logic [3:0]  wg_wstrb;

  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:6], bus.addr[1:0]};

  // Bus decode
  assign wr      = |bus.wstrb;
  assign sel     = bus.addr[5:2];
  assign ctrl_wr = wr && (sel == WsCtrl);
  assign tbl_we  = wr && (sel[3:2] == 2'b01);
  assign busy    = (state_q != StIdle);
  // Stop wins over start in the same write; a start while busy is dropped.
  assign start_go = ctrl_wr && bus.wdata[0] && !bus.wdata[2] && !busy;
  assign stop_go  = ctrl_wr && bus.wdata[2] && busy;

  assign hold_zero = (hold_cnt_q == 32'd0);
  // >= rather than == so a COUNT lowered mid-playback still ends the pass.
  assign last_step = ({1'b0, cur_idx_q} >= (count_q - CntW'(1)));

  wave_seq_table #(
    .Depth (Depth),
    .IdxW  (IdxW)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .we_i        (tbl_we),
    .widx_i      (tidx_q),
    .wfield_i    (tbl_field_e'(sel[1:0])),
    .wdata_i     (bus.wdata),
    .cpu_idx_i   (tidx_q),
    .cpu_entry_o (cpu_entry),
    .seq_idx_i   (cur_idx_q),
    .seq_entry_o (seq_entry)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_go) state_d = StLoad;
      StLoad:   state_d = StWrMode;
      StWrMode: state_d = StWrP1;
      StWrP1:   state_d = StWrP2;
      StWrP2:   state_d = StHold;
      StHold: begin
        if (hold_zero) state_d = (last_step && !loop_q) ? StWrOff : StLoad;
      end
      StWrOff:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // The OFF write itself is already the stop action; a stop there just lets it finish.
    if (stop_go && (state_q != StWrOff)) state_d = StWrOff;
  end

  // FSM outputs: wave_gen write port
  always_comb begin
    wg_wstrb = 4'h0;
    wg_addr  = 32'd0;
    wg_wdata = 32'd0;
    unique case (state_q)
      StWrMode: begin
        wg_wstrb = 4'hF;
        wg_addr  = wg_reg_addr(WgMode);
        wg_wdata = 32'(work_q.mode);
      end
      StWrP1: begin
        wg_wstrb = 4'hF;
        wg_addr  = wg_reg_addr(WgParam1);
        wg_wdata = 32'(work_q.p1);
      end
      StWrP2: begin
        wg_wstrb = 4'hF;
        wg_addr  = wg_reg_addr(WgParam2);
        wg_wdata = 32'(work_q.p2);
      end
      StWrOff: begin
        wg_wstrb = 4'hF;
        wg_addr  = wg_reg_addr(WgMode);
        wg_wdata = 32'(ModeOff);
      end
      default: ;
    endcase
  end

  assign bus.wg_wstrb = wg_wstrb;
  assign bus.wg_addr  = wg_addr;
  assign bus.wg_wdata = wg_wdata;
  assign bus.irq      = done_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      loop_q     <= 1'b0;
      count_q    <= CntW'(1);
      tidx_q     <= '0;
      cur_idx_q  <= '0;
      done_q     <= 1'b0;
      work_q     <= '0;
      hold_cnt_q <= 32'd0;
    end else begin
      loop_q     <= loop_d;
      count_q    <= count_d;
      tidx_q     <= tidx_d;
      cur_idx_q  <= cur_idx_d;
      done_q     <= done_d;
      work_q     <= work_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    loop_d     = loop_q;
    count_d    = count_q;
    tidx_d     = tidx_q;
    cur_idx_d  = cur_idx_q;
    done_d     = done_q;
    work_d     = work_q;
    hold_cnt_d = hold_cnt_q;

    if (ctrl_wr) loop_d = bus.wdata[1];

    if (wr && (sel == WsCount)) begin
      if (bus.wdata == 32'd0) begin
        count_d = CntW'(1);
      end else if (bus.wdata > 32'(Depth)) begin
        count_d = CntW'(Depth);
      end else begin
        count_d = bus.wdata[CntW-1:0];
      end
    end

    if (wr && (sel == WsTidx)) tidx_d = bus.wdata[IdxW-1:0];
    // Depth is a power of two, so the increment wraps by itself
    if (wr && (sel == WsTdur)) tidx_d = tidx_q + IdxW'(1);

    if (state_q == StLoad) work_d = seq_entry;

    // Loaded with dur-1 so HOLD lasts dur cycles; dur=0 behaves as 1.
    if (state_q == StWrP2) begin
      hold_cnt_d = (work_q.dur == 32'd0) ? 32'd0 : work_q.dur - 32'd1;
    end else if ((state_q == StHold) && !hold_zero) begin
      hold_cnt_d = hold_cnt_q - 32'd1;
    end

    if ((state_q == StHold) && hold_zero) begin
      cur_idx_d = last_step ? '0 : cur_idx_q + IdxW'(1);
    end
    if (state_q == StWrOff) cur_idx_d = '0;

    // Priority low to high: STATUS clear, start clear, end-of-sequence set.
    if (wr && (sel == WsStatus)) done_d = 1'b0;
    if (start_go) done_d = 1'b0;
    if (state_q == StWrOff) done_d = 1'b1;
  end

  // CPU readback
  always_comb begin
    rdata = 32'd0;
    case (sel)
      WsCtrl:   rdata = {30'b0, loop_q, busy};
      WsStatus: begin
        rdata[7:4] = 4'(cur_idx_q);
        rdata[1]   = done_q;
        rdata[0]   = busy;
      end
      WsCount:  rdata = 32'(count_q);
      WsTidx:   rdata = 32'(tidx_q);
      WsTmode:  rdata = 32'(cpu_entry.mode);
      WsTp1:    rdata = 32'(cpu_entry.p1);
      WsTp2:    rdata = 32'(cpu_entry.p2);
      WsTdur:   rdata = cpu_entry.dur;
      default:  rdata = 32'd0;
    endcase
  end

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_wave_seq.sv
module tb_wave_seq;

  localparam logic [3:0] RCtrl = 4'd0, RStatus = 4'd1, RCount = 4'd2, RTidx = 4'd3;
  localparam logic [3:0] RTmode = 4'd4, RTp1 = 4'd5, RTp2 = 4'd6, RTdur = 4'd7;

  logic clk = 1'b0;
  logic reset;

  wave_seq_if bus ();

  wave_seq #(
    .Depth (8),
    .IdxW  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] d;
  } wg_exp_t;

  wg_exp_t exp_q[$];
  wg_exp_t mon_got, mon_want;
  int n_checks = 0;
  int n_errors = 0;
  int t_edge;

  // Scoreboard: every wave_gen strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.wg_wstrb !== 4'h0) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL wg_unexpected: cyc %0d addr 0x%0h data 0x%0h, expected no write",
               cyc, bus.wg_addr, bus.wg_wdata);
      end
      if (exp_q.size() != 0) begin
        mon_want = exp_q.pop_front();
        mon_got  = '{c: cyc, a: bus.wg_addr, d: bus.wg_wdata};
        n_checks++;
        assert ((mon_got === mon_want) && (bus.wg_wstrb === 4'hF)) else begin
          n_errors++;
          $error("FAIL wg_write: got cyc %0d addr 0x%0h data 0x%0h strb 0x%0h, expected cyc %0d addr 0x%0h data 0x%0h strb 0xf",
                 mon_got.c, mon_got.a, mon_got.d, bus.wg_wstrb,
                 mon_want.c, mon_want.a, mon_want.d);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0] r, input logic [31:0] d);
    @(negedge clk);
    bus.wstrb = 4'hF;
    bus.addr  = {26'b0, r, 2'b00};
    bus.wdata = d;
    t_edge    = cyc + 1;
  endtask

  task automatic rel();
    @(negedge clk);
    bus.wstrb = 4'h0;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d);
    drv(r, d);
    rel();
  endtask

  task automatic check_rd(input string tag, input logic [3:0] r, input logic [31:0] exp);
    logic [31:0] v;
    @(negedge clk);
    bus.addr = {26'b0, r, 2'b00};
    #1 v = bus.rdata;
    check(tag, v, exp);
  endtask

  task automatic load_entry(input int idx, input int mode, input int p1, input int p2,
                            input int dur);
    wr(RTidx, 32'(idx));
    wr(RTmode, 32'(mode));
    wr(RTp1, 32'(p1));
    wr(RTp2, 32'(p2));
    wr(RTdur, 32'(dur));
  endtask

  task automatic push_step(input int t, input int mode, input int p1, input int p2);
    exp_q.push_back('{c: 32'(t), a: 32'h0, d: 32'(mode)});
    exp_q.push_back('{c: 32'(t + 1), a: 32'h4, d: 32'(p1)});
    exp_q.push_back('{c: 32'(t + 2), a: 32'h8, d: 32'(p2)});
  endtask

  task automatic push_off(input int t);
    exp_q.push_back('{c: 32'(t), a: 32'h0, d: 32'h0});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset     = 1'b1;
    bus.wstrb = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_wg_wstrb", 32'(bus.wg_wstrb), 32'h0);
    check("rst_wg_addr", bus.wg_addr, 32'h0);
    check("rst_wg_wdata", bus.wg_wdata, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    check_rd("rst_ctrl", RCtrl, 32'h0);
    check_rd("rst_status", RStatus, 32'h0);
    check_rd("rst_count", RCount, 32'h1);
    check_rd("rst_tidx", RTidx, 32'h0);
    check_rd("rst_tdur", RTdur, 32'h0);

    // 1: single step, no loop
    load_entry(0, 1, 5, 1, 10);
    wr(RCount, 32'd1);
    drv(RCtrl, 32'h1);
    t = t_edge;
    push_step(t + 1, 1, 5, 1);
    push_off(t + 14);
    rel();
    wait_until(t + 6);
    check_rd("t1_busy_in_hold", RCtrl, 32'h1);
    drain("t1_drain");
    wait_until(t + 16);
    check("t1_irq", 32'(bus.irq), 32'h1);
    check_rd("t1_status", RStatus, 32'h2);

    // 2: three entries looping, dur=0 treated as 1
    load_entry(0, 2, 100, 50, 4);
    load_entry(1, 4, 7, 8, 6);
    load_entry(2, 6, 9, 10, 0);
    wr(RCount, 32'd3);
    drv(RCtrl, 32'h3);
    t = t_edge;
    push_step(t + 1, 2, 100, 50);
    push_step(t + 9, 4, 7, 8);
    push_step(t + 19, 6, 9, 10);
    push_step(t + 24, 2, 100, 50);
    push_step(t + 32, 4, 7, 8);
    rel();
    wait_until(t + 2);
    check_rd("t2_status_started", RStatus, 32'h1);
    wait_until(t + 20);
    check_rd("t2_status_idx2", RStatus, 32'h21);

    // 3: stop during HOLD of the second pass of entry1
    wait_until(t + 35);
    drv(RCtrl, 32'h4);
    push_off(t_edge);
    t = t_edge;
    rel();
    drain("t3_drain");
    wait_until(t + 2);
    check_rd("t3_status", RStatus, 32'h2);
    check_rd("t3_ctrl", RCtrl, 32'h0);
    wr(RCtrl, 32'h4);
    repeat (4) @(negedge clk);
    check_rd("t3_status_2nd_stop", RStatus, 32'h2);
    check("t3_irq", 32'(bus.irq), 32'h1);

    // 4: start+stop from idle does nothing; start while busy is ignored
    wr(RCtrl, 32'h5);
    repeat (5) @(negedge clk);
    check_rd("t4_ctrl_idle", RCtrl, 32'h0);
    check_rd("t4_status_done_kept", RStatus, 32'h2);
    wr(RCount, 32'd1);
    drv(RCtrl, 32'h1);
    t = t_edge;
    push_step(t + 1, 2, 100, 50);
    push_off(t + 8);
    rel();
    wait_until(t + 3);
    wr(RCtrl, 32'h1);
    drain("t4_drain");
    wait_until(t + 10);
    check_rd("t4_status", RStatus, 32'h2);

    // 5: register edge cases and a table rewrite during playback
    wr(RCount, 32'd0);
    check_rd("t5_count0", RCount, 32'h1);
    wr(RCount, 32'd20);
    check_rd("t5_count20", RCount, 32'h8);
    wr(RTidx, 32'd7);
    wr(RTmode, 32'd5);
    check_rd("t5_tmode7", RTmode, 32'h5);
    check_rd("t5_tidx7", RTidx, 32'h7);
    wr(RTdur, 32'd9);
    check_rd("t5_tidx_wrap", RTidx, 32'h0);
    check_rd("t5_tdur0", RTdur, 32'h4);
    check_rd("t5_tp1_0", RTp1, 32'd100);
    check_rd("t5_unused_addr", 4'd9, 32'h0);
    load_entry(0, 3, 11, 12, 20);
    load_entry(1, 4, 7, 8, 6);
    wr(RCount, 32'd2);
    drv(RCtrl, 32'h1);
    t = t_edge;
    push_step(t + 1, 3, 11, 12);
    push_step(t + 25, 5, 21, 22);
    push_off(t + 31);
    rel();
    wait_until(t + 4);
    load_entry(1, 5, 21, 22, 3);
    drain("t5_drain");
    wait_until(t + 33);
    check_rd("t5_status", RStatus, 32'h2);

    // 6: reset during WR_P1
    drv(RCtrl, 32'h1);
    t = t_edge;
    exp_q.push_back('{c: 32'(t + 1), a: 32'h0, d: 32'd3});
    exp_q.push_back('{c: 32'(t + 2), a: 32'h4, d: 32'd11});
    rel();
    wait_until(t + 2);
    reset = 1'b1;
    @(negedge clk);
    check("t6_wg_wstrb", 32'(bus.wg_wstrb), 32'h0);
    check("t6_wg_addr", bus.wg_addr, 32'h0);
    check("t6_wg_wdata", bus.wg_wdata, 32'h0);
    check("t6_irq", 32'(bus.irq), 32'h0);
    check_rd("t6_ctrl", RCtrl, 32'h0);
    check_rd("t6_count", RCount, 32'h1);
    check_rd("t6_tidx", RTidx, 32'h0);
    check_rd("t6_status", RStatus, 32'h0);
    reset = 1'b0;
    check_rd("t6_tmode0", RTmode, 32'h0);
    check_rd("t6_tdur0", RTdur, 32'h0);
    wr(RTidx, 32'd1);
    check_rd("t6_tmode1", RTmode, 32'h0);
    check_rd("t6_tp2_1", RTp2, 32'h0);
    check("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
